// File: rtl/dac_ramp_gen_pkg.sv
// Shared definitions for the DAC ramp generator: ramp mode encodings.
package dac_ramp_gen_pkg;

    typedef enum logic [1:0] {
        MODE_SAW_UP = 2'b00,
        MODE_SAW_DN = 2'b01,
        MODE_TRI    = 2'b10,
        MODE_HOLD   = 2'b11
    } ramp_mode_e;

endpackage

// File: rtl/dac_ramp_gen_prescaler.sv
// Clock prescaler for the ramp generator: flags a step every div+1 enabled cycles.
module ramp_prescaler #(
    parameter int DIV_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en,
    input  logic                 clr,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 step_en
);

    logic [DIV_WIDTH-1:0] pre;
    logic                 terminal;

    // >= rather than == so that lowering div mid-count never strands the counter
    assign terminal = (pre >= div);
    assign step_en  = en & ~clr & terminal;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pre <= '0;
        end else if (clr) begin
            pre <= '0;
        end else if (en) begin
            if (terminal) pre <= '0;
            else          pre <= pre + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/dac_ramp_gen.sv
// Programmable ramp generator feeding the DAC code: saw-up, saw-down, triangle
// and hold modes with prescaled stepping and per-step / wrap strobes.
module dac_ramp_gen
    import dac_ramp_gen_pkg::*;
#(
    parameter int CNT_WIDTH = 3,
    parameter int DIV_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic [1:0]           mode_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic [CNT_WIDTH-1:0] max_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 dir_o,
    output logic                 step_o,
    output logic                 wrap_o
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic                 step_en;
    logic                 presc_en;
    logic [CNT_WIDTH+1:0] nxt;

    // Next ramp state packed as {wrap, dir, cnt}
    function automatic logic [CNT_WIDTH+1:0] ramp_next(
        input ramp_mode_e           mode,
        input logic [CNT_WIDTH-1:0] cnt,
        input logic [CNT_WIDTH-1:0] top,
        input logic                 dir
    );
        logic [CNT_WIDTH-1:0] c;
        logic                 d;
        logic                 w;
        c = cnt;
        d = dir;
        w = 1'b0;
        case (mode)
            MODE_SAW_UP: begin
                d = 1'b1;
                if (cnt >= top) begin c = '0; w = 1'b1; end
                else            c = cnt + ONE;
            end
            MODE_SAW_DN: begin
                d = 1'b0;
                if (cnt == '0)     begin c = top; w = 1'b1; end
                else if (cnt > top) c = top;
                else                c = cnt - ONE;
            end
            MODE_TRI: begin
                if (dir) begin
                    if (cnt >= top) begin
                        d = 1'b0;
                        c = (top == '0) ? '0 : top - ONE;
                        w = 1'b1;
                    end else begin
                        c = cnt + ONE;
                    end
                end else begin
                    if (cnt == '0) begin
                        d = 1'b1;
                        c = (top == '0) ? '0 : ONE;
                        w = 1'b1;
                    end else if (cnt > top) begin
                        c = top;
                    end else begin
                        c = cnt - ONE;
                    end
                end
            end
            default: begin
                c = cnt;
                d = dir;
            end
        endcase
        return {w, d, c};
    endfunction

    assign presc_en = en_i & (ramp_mode_e'(mode_i) != MODE_HOLD);

    ramp_prescaler #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_prescaler (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en      (presc_en),
        .clr     (clr_i),
        .div     (div_i),
        .step_en (step_en)
    );

    assign nxt = ramp_next(ramp_mode_e'(mode_i), cnt_o, max_i, dir_o);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_o  <= '0;
            dir_o  <= 1'b1;
            step_o <= 1'b0;
            wrap_o <= 1'b0;
        end else if (clr_i) begin
            cnt_o  <= '0;
            dir_o  <= 1'b1;
            step_o <= 1'b0;
            wrap_o <= 1'b0;
        end else begin
            step_o <= step_en;
            wrap_o <= step_en & nxt[CNT_WIDTH+1];
            if (step_en) begin
                cnt_o <= nxt[CNT_WIDTH-1:0];
                dir_o <= nxt[CNT_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_dac_ramp_gen.sv
// Directed self-checking bench for dac_ramp_gen with hand-derived ramp sequences.
module tb_dac_ramp_gen;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [1:0] mode;
    logic [3:0] div;
    logic [2:0] max;
    logic [2:0] cnt;
    logic       dir;
    logic       step;
    logic       wrap;

    int n_checks = 0;
    int n_errors = 0;

    dac_ramp_gen #(
        .CNT_WIDTH(3),
        .DIV_WIDTH(4)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .en_i    (en),
        .clr_i   (clr),
        .mode_i  (mode),
        .div_i   (div),
        .max_i   (max),
        .cnt_o   (cnt),
        .dir_o   (dir),
        .step_o  (step),
        .wrap_o  (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_all(input string tag, input int c, input int d, input int s, input int w);
        chk({tag, ".cnt"},  32'(cnt),  32'(c));
        chk({tag, ".dir"},  32'(dir),  32'(d));
        chk({tag, ".step"}, 32'(step), 32'(s));
        chk({tag, ".wrap"}, 32'(wrap), 32'(w));
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick(1);
        chk_all("clr", 0, 1, 0, 0);
        clr = 1'b0;
    endtask

    int tri_cnt [12] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2};
    int tri_dir [12] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
    int tri_wrap[12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    int dn_seq  [8]  = '{0, 6, 5, 4, 3, 2, 1, 0};

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        mode  = 2'b00;
        div   = 4'd0;
        max   = 3'd7;
        tick(2);
        chk_all("reset", 0, 1, 0, 0);
        rst_n = 1'b1;

        // saw-up legacy: 1..7,0..7,0 over 16 steps
        en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick(1);
            chk_all($sformatf("saw_up[%0d]", i), i % 8, 1, 1, (i % 8 == 0) ? 1 : 0);
        end

        // triangle max 5
        do_clear();
        mode = 2'b10;
        max  = 3'd5;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            chk_all($sformatf("tri[%0d]", i), tri_cnt[i], tri_dir[i], 1, tri_wrap[i]);
        end

        // saw-down max 6, div 2: each value held 3 cycles
        do_clear();
        mode = 2'b01;
        max  = 3'd6;
        div  = 4'd2;
        for (int i = 1; i <= 24; i++) begin
            int k;
            int v;
            k = i / 3;
            v = (k >= 8) ? dn_seq[k - 7] : dn_seq[k];
            tick(1);
            chk_all($sformatf("saw_dn[%0d]", i), v, (k == 0) ? 1 : 0,
                    (i % 3 == 0) ? 1 : 0, ((i % 3 == 0) && v == 6) ? 1 : 0);
        end

        // enable freeze then clear with enable high
        do_clear();
        mode = 2'b00;
        max  = 3'd7;
        div  = 4'd0;
        tick(4);
        chk_all("pre_freeze", 4, 1, 1, 0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk_all($sformatf("freeze[%0d]", i), 4, 1, 0, 0);
        end
        en = 1'b1;
        tick(1);
        chk_all("resume", 5, 1, 1, 0);
        do_clear();

        // saw-up at 6, max lowered to 3
        tick(6);
        chk_all("saw6", 6, 1, 1, 0);
        max = 3'd3;
        tick(1);
        chk_all("saw_max_drop", 0, 1, 1, 1);

        // triangle rising at 6, max lowered to 3
        max = 3'd7;
        do_clear();
        mode = 2'b10;
        tick(6);
        chk_all("tri6", 6, 1, 1, 0);
        max = 3'd3;
        tick(1);
        chk_all("tri_max_drop", 2, 0, 1, 1);

        // async reset mid-triangle at cnt 3 falling
        max = 3'd5;
        do_clear();
        tick(7);
        chk_all("tri_pre_rst", 3, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 1, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mode  = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk_all($sformatf("hold[%0d]", i), 0, 1, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
